// File: rtl/mvm_stream_driver.sv
// mvm_stream_driver
//   Stream wrapper around the 8x8 matrix-vector multiply core. It collects one
//   packet (K*K matrix words, row-major, then K vector words) from a
//   valid/ready input, replays it to the core as gap-free bursts, starts the
//   compute, captures the K results and re-emits them on a valid/ready output.
//   The core itself cannot stall, so all buffering lives here.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   input stream handshake, in_data = B-bit signed word
//   out_valid/out_ready output stream handshake, out_data = 2B-bit signed y[i],
//                       out_last marks y[K-1]
//   err                 sticky flag: core never raised done within TIMEOUT
//   core_*              direct connection to the multiply core
module mvm_stream_driver #(
    parameter int K       = 8,
    parameter int LOGK    = 3,
    parameter int B       = 8,
    parameter int OUT_LAT = 1,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [B-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*B-1:0]   out_data,
    output logic             out_last,
    output logic             err,
    output logic             core_loadMatrix,
    output logic             core_loadVector,
    output logic             core_start,
    output logic [B-1:0]     core_data_in,
    input  logic             core_done,
    input  logic [2*B-1:0]   core_data_out
);
    localparam int NA = K * K;
    localparam int NW = K * K + K;
    localparam int AW = $clog2(NW);
    localparam int CW = $clog2(NW + OUT_LAT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        COLLECT, SEND_AC, SEND_A, GAP, SEND_XC, SEND_X, GAP2, START,
        WAIT_DONE, CAPTURE, DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic            err_q, err_d;
    logic            lm_q, lm_d;
    logic            lv_q, lv_d;
    logic            st_q, st_d;

    logic signed [B-1:0]   in_mem  [NW];
    logic signed [2*B-1:0] res_mem [K];

    logic            in_fire;
    logic            cap_en;
    logic [LOGK-1:0] cap_idx;

    assign in_ready  = (state_q == COLLECT) && !reset;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state_q == DRAIN);
    assign out_data  = out_valid ? res_mem[cnt_q[LOGK-1:0]] : '0;
    assign out_last  = out_valid && (cnt_q == CW'(K - 1));
    assign err       = err_q;

    assign core_loadMatrix = lm_q;
    assign core_loadVector = lv_q;
    assign core_start      = st_q;

    // CAPTURE counts OUT_LAT-1 settle cycles before the first result word,
    // so the result slot is the count minus that offset.
    assign cap_en  = (state_q == CAPTURE) && ((cnt_q + CW'(1)) >= CW'(OUT_LAT));
    assign cap_idx = cnt_q[LOGK-1:0] - LOGK'(OUT_LAT - 1);

    always_comb begin
        core_data_in = '0;
        if (state_q == SEND_A) begin
            core_data_in = in_mem[cnt_q[AW-1:0]];
        end else if (state_q == SEND_X) begin
            core_data_in = in_mem[cnt_q[AW-1:0] + AW'(NA)];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        err_d   = err_q;
        case (state_q)
            COLLECT: begin
                if (in_fire) begin
                    if (cnt_q == CW'(NW - 1)) begin
                        cnt_d   = '0;
                        state_d = SEND_AC;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            SEND_AC: begin
                cnt_d   = '0;
                state_d = SEND_A;
            end
            SEND_A: begin
                if (cnt_q == CW'(NA - 1)) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    state_d = SEND_XC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SEND_XC: begin
                cnt_d   = '0;
                state_d = SEND_X;
            end
            SEND_X: begin
                if (cnt_q == CW'(K - 1)) begin
                    cnt_d   = '0;
                    state_d = GAP2;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP2: begin
                if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            START: begin
                wd_d    = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (core_done) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    // Core never answered: flag it and drop the packet.
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            CAPTURE: begin
                if (cnt_q == CW'(OUT_LAT + K - 2)) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (cnt_q == CW'(K - 1)) begin
                        cnt_d   = '0;
                        state_d = COLLECT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = COLLECT;
            end
        endcase
        // Strobes come from flops keyed on the next state so they line up
        // with the state they belong to and never glitch.
        lm_d = (state_d == SEND_AC);
        lv_d = (state_d == SEND_XC);
        st_d = (state_d == START);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            lm_q    <= 1'b0;
            lv_q    <= 1'b0;
            st_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            lm_q    <= lm_d;
            lv_q    <= lv_d;
            st_q    <= st_d;
        end
    end

    // Data storage carries no reset; the control state decides what is live.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            in_mem[cnt_q[AW-1:0]] <= in_data;
        end
        if (cap_en) begin
            res_mem[cap_idx] <= core_data_out;
        end
    end

endmodule
